// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable divider / clock-enable generator.
// Each channel divides clk by a runtime-loadable divisor D and produces a
// ~50% duty clk_out (low floor(D/2), high ceil(D/2)) plus a one-cycle tick
// at the last count of every period. New divisors are staged in a pending
// register and only take effect at a period boundary, so no period is ever
// truncated or glitched.
// Optional feature: define CLK_DIV_PHASE_SYNC_EN to add the phase_sync input,
// which restarts every channel at cnt=0 (applying pending divisors) so all
// channels become phase-aligned. Without it channels realign only via rst.
module clk_div_multi #(
  parameter int CH      = 4,
  parameter int DIV_W   = 32,
  parameter int DEF_DIV = 100_000,
  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [DIV_W-1:0] wr_div,
`ifdef CLK_DIV_PHASE_SYNC_EN
  input  logic             phase_sync,
`endif
  output logic [CH-1:0]    clk_out,
  output logic [CH-1:0]    tick,
  output logic [CH-1:0]    upd_pend
);

  localparam logic [DIV_W-1:0] DEF_D  = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ONE    = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO    = DIV_W'(2);
  // One extra bit so CH itself is representable for the range check.
  localparam logic [CH_W:0]    CH_LIM = (CH_W+1)'(CH);

  logic sync;
  logic wr_ok;

`ifdef CLK_DIV_PHASE_SYNC_EN
  assign sync = phase_sync;
`else
  assign sync = 1'b0;
`endif

  // Writes addressed beyond the last channel are dropped.
  assign wr_ok = wr_en && ({1'b0, wr_ch} < CH_LIM);

  // Divided output level for count c under divisor d (D=0 means disabled).
  function automatic logic out_level(input logic [DIV_W-1:0] c,
                                     input logic [DIV_W-1:0] d);
    return (d != '0) && (c >= (d >> 1));
  endfunction

  // Tick level: last count of the period (D=1 ticks every cycle).
  function automatic logic tick_level(input logic [DIV_W-1:0] c,
                                      input logic [DIV_W-1:0] d);
    return (d != '0) && (c == (d - ONE));
  endfunction

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act_div;
    logic [DIV_W-1:0] pend_div;
    logic             pend;
    logic             clk_q;
    logic             tick_q;

    logic [DIV_W-1:0] cnt_n;
    logic [DIV_W-1:0] div_n;
    logic [DIV_W-1:0] pend_div_n;
    logic             pend_n;
    logic             clk_n;
    logic             tick_n;
    logic             wr_hit;
    logic             low_d;
    logic             wrap;
    logic             apply;
    logic             restart;

    // Next-state decode: wrap/apply decision, counter, staged divisor, outputs.
    always_comb begin
      wr_hit  = wr_ok && (wr_ch == CH_W'(g));
      low_d   = (act_div < TWO);
      wrap    = en && !low_d && (cnt == (act_div - ONE));
      // D=0/1 have no period to finish, so a pending value lands at once.
      apply   = pend && (wrap || low_d || sync);
      restart = apply || sync;
      div_n   = apply ? pend_div : act_div;

      if (restart || (en && (low_d || wrap))) begin
        cnt_n = '0;
      end else if (en) begin
        cnt_n = cnt + ONE;
      end else begin
        cnt_n = cnt;
      end

      // A write coinciding with apply stays pending; apply used the old value.
      pend_div_n = wr_hit ? wr_div : pend_div;
      if (wr_hit) begin
        pend_n = 1'b1;
      end else if (apply) begin
        pend_n = 1'b0;
      end else begin
        pend_n = pend;
      end

      if (en || restart) begin
        clk_n = out_level(cnt_n, div_n);
      end else begin
        clk_n = clk_q;
      end
      tick_n = (en || sync) && tick_level(cnt_n, div_n);
    end

    // Channel state and registered outputs, asynchronously reset to DEF_DIV.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt      <= '0;
        act_div  <= DEF_D;
        pend_div <= DEF_D;
        pend     <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        cnt      <= cnt_n;
        act_div  <= div_n;
        pend_div <= pend_div_n;
        pend     <= pend_n;
        clk_q    <= clk_n;
        tick_q   <= tick_n;
      end
    end

    assign clk_out[g]  = clk_q;
    assign tick[g]     = tick_q;
    assign upd_pend[g] = pend;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Testbench for clk_div_multi: CH=5, DIV_W=16, DEF_DIV=4.
// A period-position model (enabled cycles since last restart, modulo D)
// predicts every output each cycle; directed sequences add literal checks.
module tb_clk_div_multi;

  localparam int CH    = 5;
  localparam int DIV_W = 16;
  localparam int CH_W  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [DIV_W-1:0] wr_div;
  logic             ps_drv = 1'b0;
  logic [CH-1:0]    clk_out;
  logic [CH-1:0]    tick;
  logic [CH-1:0]    upd_pend;

  int checks = 0;
  int errors = 0;

  clk_div_multi #(.CH(CH), .DIV_W(DIV_W), .DEF_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_div   (wr_div),
`ifdef CLK_DIV_PHASE_SYNC_EN
    .phase_sync(ps_drv),
`endif
    .clk_out  (clk_out),
    .tick     (tick),
    .upd_pend (upd_pend)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_d   [CH];
  int m_pd  [CH];
  bit m_p   [CH];
  int m_el  [CH];
  bit m_clk [CH];
  bit m_tick[CH];

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      int  d, pos, nd;
      bit  wrap, apply, wr, restart;
      if (rst) begin
        m_d[c] = 4; m_pd[c] = 4; m_p[c] = 0; m_el[c] = 0;
        m_clk[c] = 0; m_tick[c] = 0;
      end else begin
        d       = m_d[c];
        pos     = (d >= 2) ? (m_el[c] % d) : 0;
        wrap    = en && (d >= 2) && (pos == d - 1);
        apply   = m_p[c] && (wrap || d < 2 || ps_drv);
        wr      = wr_en && (int'(wr_ch) == c);
        restart = apply || ps_drv;
        nd      = apply ? m_pd[c] : d;
        if (restart || nd < 2) m_el[c] = 0;
        else if (en) m_el[c] = m_el[c] + 1;
        if (wr) begin
          m_pd[c] = int'(wr_div);
          m_p[c]  = 1;
        end else if (apply) begin
          m_p[c] = 0;
        end
        m_d[c] = nd;
        pos = (nd >= 2) ? (m_el[c] % nd) : 0;
        if (en || restart) m_clk[c] = (nd != 0) && (pos >= nd / 2);
        m_tick[c] = (en || ps_drv) && (nd != 0) && (pos == nd - 1);
      end
    end
  endtask

  // Single compare process: advance model at each edge, check 1 ns later.
  always @(posedge clk) begin
    logic [CH-1:0] e_clk, e_tick, e_pend;
    model_edge();
    #1;
    for (int c = 0; c < CH; c++) begin
      e_clk[c]  = m_clk[c];
      e_tick[c] = m_tick[c];
      e_pend[c] = m_p[c];
    end
    checks += 3;
    if (clk_out !== e_clk) begin
      errors++;
      $display("FAIL model_clk_out t=%0t actual=%b required=%b", $time, clk_out, e_clk);
    end
    if (tick !== e_tick) begin
      errors++;
      $display("FAIL model_tick t=%0t actual=%b required=%b", $time, tick, e_tick);
    end
    if (upd_pend !== e_pend) begin
      errors++;
      $display("FAIL model_upd_pend t=%0t actual=%b required=%b", $time, upd_pend, e_pend);
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic write(input int c, input int d);
    wr_en  = 1'b1;
    wr_ch  = CH_W'(c);
    wr_div = DIV_W'(d);
    step();
    wr_en  = 1'b0;
  endtask

  task automatic wait_clear(input int c);
    int n = 0;
    while (upd_pend[c] && n < 40) begin
      step();
      n++;
    end
    chk("wait_apply_timeout", {31'd0, upd_pend[c]}, 32'd0);
  endtask

  task automatic wait_tick(input int c);
    int n = 0;
    while (!tick[c] && n < 40) begin
      step();
      n++;
    end
    chk("wait_tick_timeout", {31'd0, tick[c]}, 32'd1);
  endtask

  task automatic check_def_pattern(input string nm);
    bit pat_clk [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    bit pat_tick[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    for (int k = 0; k < 8; k++) begin
      step();
      chk({nm, "_clk"},  32'(clk_out), pat_clk[k]  ? 32'h1f : 32'h0);
      chk({nm, "_tick"}, 32'(tick),    pat_tick[k] ? 32'h1f : 32'h0);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bit exp_c1[5] = '{0, 1, 1, 1, 0};
    int n;
    rst = 1'b1; en = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_clk_out",  32'(clk_out),  32'h0);
    chk("reset_tick",     32'(tick),     32'h0);
    chk("reset_upd_pend", 32'(upd_pend), 32'h0);
    rst = 1'b0;

    // Default D=4: clk_out 0,0,1,1 with tick on cnt=3.
    check_def_pattern("def4");

    // Channel 1 -> 5 written at cnt=1; old period completes first.
    step();
    write(1, 5);
    chk("ch1_pend_a", 32'(upd_pend), 32'h02);
    step();
    chk("ch1_pend_b", 32'(upd_pend), 32'h02);
    chk("ch1_old_tick", {31'd0, tick[1]}, 32'd1);
    step();
    chk("ch1_applied", 32'(upd_pend), 32'h0);
    chk("ch1_restart_low", {31'd0, clk_out[1]}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("ch1_div5_clk", {31'd0, clk_out[1]}, {31'd0, exp_c1[k]});
      chk("ch1_div5_tick", {31'd0, tick[1]}, (k == 3) ? 32'd1 : 32'd0);
    end

    // Channel 2: D=0 disables, then D=1 holds both outputs high.
    write(2, 0);
    wait_clear(2);
    for (int k = 0; k < 3; k++) begin
      chk("ch2_d0_clk",  {31'd0, clk_out[2]}, 32'd0);
      chk("ch2_d0_tick", {31'd0, tick[2]},    32'd0);
      step();
    end
    write(2, 1);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("ch2_d1_clk",  {31'd0, clk_out[2]}, 32'd1);
      chk("ch2_d1_tick", {31'd0, tick[2]},    32'd1);
      step();
    end

    // Channel 3 at D=6: freeze at cnt=4 for 7 cycles, then resume.
    write(3, 6);
    wait_clear(3);
    repeat (4) step();
    chk("ch3_pre_freeze", {31'd0, clk_out[3]}, 32'd1);
    en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("freeze_tick", 32'(tick), 32'h0);
      chk("freeze_clk3", {31'd0, clk_out[3]}, 32'd1);
    end
    en = 1'b1;
    step();
    chk("resume_tick3", {31'd0, tick[3]}, 32'd1);
    step();
    chk("resume_wrap3", {31'd0, clk_out[3]}, 32'd0);

    // Channel 0: two writes inside one period, last value (9) wins.
    wait_tick(0);
    write(0, 7);
    write(0, 9);
    wait_clear(0);
    wait_tick(0);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[0] && n < 30);
    chk("ch0_period9", 32'(n), 32'd9);

    // Out-of-range channel writes are ignored.
    wr_en = 1'b1; wr_div = DIV_W'(3); wr_ch = CH_W'(6);
    step();
    wr_ch = CH_W'(5);
    step();
    wr_en = 1'b0;
    chk("bad_ch_ignored", 32'(upd_pend), 32'h0);
    repeat (3) step();

    // Reset mid-period drops a pending write and restores DEF_DIV.
    write(1, 7);
    chk("pre_reset_pend", 32'(upd_pend), 32'h02);
    rst = 1'b1;
    #1;
    chk("async_rst_pend", 32'(upd_pend), 32'h0);
    chk("async_rst_clk",  32'(clk_out),  32'h0);
    step();
    rst = 1'b0;
    check_def_pattern("post_rst");

`ifdef CLK_DIV_PHASE_SYNC_EN
    // Phase sync: divisors 3/4/6/8 align; all four tick together every 24.
    write(0, 3);
    write(1, 4);
    write(2, 6);
    write(3, 8);
    repeat (5) step();
    ps_drv = 1'b1;
    step();
    ps_drv = 1'b0;
    chk("sync_clk_low", 32'(clk_out), 32'h0);
    chk("sync_no_pend", 32'(upd_pend), 32'h0);
    begin
      int first = -1;
      int hits  = 0;
      for (int k = 1; k <= 48; k++) begin
        step();
        if (tick[3:0] == 4'hf) begin
          hits++;
          if (first < 0) first = k;
        end
      end
      chk("sync_first_coincide", 32'(first), 32'd23);
      chk("sync_coincide_count", 32'(hits),  32'd2);
    end
`endif

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1);
  end

endmodule
